// File: rtl/pipe_pkg.sv
// Shared definitions for the five-stage microinstruction pipeline controller:
// FSM encoding, stage indices and microinstruction T-bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } pipe_state_e;

    localparam int NUM_STAGES = 5;

    // Bit positions inside stage_en / valid (stage i+1 lives at bit i).
    localparam int STG_FETCH   = 0;
    localparam int STG_DECODE  = 1;
    localparam int STG_OPFETCH = 2;
    localparam int STG_EXEC    = 3;
    localparam int STG_WB      = 4;

    // Microinstruction T-bit indices, consumed by the hazard-detection unit.
    localparam int WR_READ  = 0;
    localparam int WR_WRITE = 1;
    localparam int R_READ   = 2;
    localparam int R_WRITE  = 3;
    localparam int C_READ   = 4;
    localparam int C_WRITE  = 5;
    localparam int PC_WRITE = 6;
    localparam int T_BITS   = 7;

    localparam logic [NUM_STAGES-1:0] EN_NONE  = 5'b00000;
    localparam logic [NUM_STAGES-1:0] EN_STALL = 5'b11100;

    // Stage enables while advancing: everything moves, fetch only when allowed.
    function automatic logic [NUM_STAGES-1:0] advance_en(input logic fetch_on);
        return {4'b1111, fetch_on};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Synchronous clear has priority over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (clear) begin
            r_count <= '0;
        end else if (inc && !w_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage microinstruction pipeline controller: fetch PC, stage enables,
// stall bubbles, branch flushes and halt/drain. Counters need PIPE_PERF_CNT_EN.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              branch_update,
    input  logic              branch_taken,
    input  logic [PC_W-1:0]   branch_target,
    input  logic              halt_req,
    input  logic              resume,
    output logic [PC_W-1:0]   pc,
    output logic [4:0]        stage_en,
    output logic [4:0]        valid,
    output logic              bubble,
    output logic              flush,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output pipe_state_e       o_dbg_state
);

    pipe_state_e      r_state;
    pipe_state_e      w_next_state;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  w_pc_next;
    logic [4:0]       r_valid;
    logic [4:0]       w_valid_next;
    logic [4:0]       w_stage_en;
    logic             w_bubble;
    logic             w_flush;
    logic             w_halted;
    logic             w_taken;
    logic             w_fetch_on;

    assign w_taken    = branch_update & branch_taken;
    // Fetch runs only in RUN and stops in the very cycle a halt is requested.
    assign w_fetch_on = (r_state == ST_RUN) && !halt_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc    <= '0;
            r_valid <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            r_valid <= w_valid_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_valid_next = r_valid;
        w_stage_en   = EN_NONE;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        w_halted     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_next_state = ST_RUN;
            end

            ST_RUN, ST_DRAIN: begin
                // Execute and writeback always advance; only stages 1-3 react to events.
                w_valid_next[STG_WB]   = r_valid[STG_EXEC];
                w_valid_next[STG_EXEC] = r_valid[STG_OPFETCH];

                if (w_taken) begin
                    w_flush    = 1'b1;
                    w_pc_next  = branch_target;
                    w_stage_en = advance_en(w_fetch_on);
                    w_valid_next[STG_OPFETCH:STG_FETCH] = '0;
                end else if (hold) begin
                    w_bubble   = 1'b1;
                    w_stage_en = EN_STALL;
                    w_valid_next[STG_OPFETCH] = 1'b0;
                    w_valid_next[STG_DECODE]  = r_valid[STG_DECODE];
                    w_valid_next[STG_FETCH]   = w_fetch_on & r_valid[STG_FETCH];
                end else begin
                    w_stage_en = advance_en(w_fetch_on);
                    w_valid_next[STG_OPFETCH] = r_valid[STG_DECODE];
                    w_valid_next[STG_DECODE]  = r_valid[STG_FETCH];
                    w_valid_next[STG_FETCH]   = w_fetch_on;
                    if (w_fetch_on) begin
                        w_pc_next = r_pc + PC_W'(1);
                    end
                end

                if ((r_state == ST_RUN) && halt_req) begin
                    w_next_state = ST_DRAIN;
                end else if ((r_state == ST_DRAIN) &&
                             (w_valid_next[STG_WB:STG_DECODE] == 4'b0000)) begin
                    w_next_state = ST_HALT;
                end
            end

            ST_HALT: begin
                w_halted     = 1'b1;
                w_valid_next = '0;
                if (resume) begin
                    w_next_state = ST_RUN;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign pc          = r_pc;
    assign valid       = r_valid;
    assign stage_en    = w_stage_en;
    assign bubble      = w_bubble;
    assign flush       = w_flush;
    assign halted      = w_halted;
    assign o_dbg_state = r_state;

`ifdef PIPE_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .clear   (rst),
        .inc     (w_bubble),
        .o_count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .clear   (rst),
        .inc     (w_flush),
        .o_count (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
